regfile_dump_ctrl: RTL and testbench
====================================

Name: regfile_dump_ctrl

Overview:
Hardware read-out engine for the Integer_Datapath register file. It is the reader counterpart to the register-write sequence that loads the file through DT/D_Addr/D_En. On a start pulse it steps the S and T read ports through paired addresses. It captures S data (ALU_OUT with FS = pass-S) and T data (D_OUT), then streams each pair out on a valid/ready interface to a debug/trace consumer. The datapath's write path is never touched.

Parameters:
PAIRS, 16, number of S/T pairs read per dump (1..32)
S_BASE, 5'h00, first S address
T_BASE, 5'h10, first T address
READ_LAT, 1, cycles from address drive to data capture (>=1; 0 illegal)
FS_PASS_S, 5'h00, ALU function code that passes S to ALU_OUT
Y_SEL_ALU, 3'b010, Y_Sel value selecting the ALU result

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a dump; honoured only in IDLE
abort  in  1  cancel the dump in progress; return to IDLE next edge
ALU_OUT  in  32  datapath ALU result (S data while FS = FS_PASS_S)
D_OUT  in  32  datapath T-port read data
S_Addr  out  5  S read address to datapath
T_Addr  out  5  T read address to datapath
FS  out  5  ALU function select; constant FS_PASS_S
Y_Sel  out  3  output mux select; constant Y_SEL_ALU
T_Sel  out  1  constant 0 (T from register file)
D_En  out  1  constant 0 (never writes)
HILO_ld  out  1  constant 0
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after the final beat is accepted
out_valid  out  1  pair available
out_ready  in  1  consumer accepts pair
out_s_addr  out  5  S address of captured pair
out_s_data  out  32  captured S data
out_t_addr  out  5  T address of captured pair
out_t_data  out  32  captured T data
out_last  out  1  high with out_valid on the final pair

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; idx=0; lat_cnt=0.
  - S_Addr=S_BASE, T_Addr=T_BASE.
  - out_valid, out_last, done, busy = 0; out_* data/addr = 0.
  - Reset overrides start, abort and an in-flight handshake.
- States: IDLE, RD, OUT.
- IDLE:
  - On start: S_Addr<=S_BASE, T_Addr<=T_BASE, idx<=0, lat_cnt<=0; go to RD.
  - start in any other state is ignored.
- RD:
  - Addresses are held stable; lat_cnt increments each edge.
  - On the edge where lat_cnt==READ_LAT-1: capture ALU_OUT->out_s_data, D_OUT->out_t_data and the current addresses into out_s_addr/out_t_addr; set out_valid=1 and out_last=(idx==PAIRS-1); go to OUT.
- OUT:
  - Outputs are held stable until out_valid&&out_ready.
  - out_ready while out_valid=0 has no effect.
  - On handshake, not last: idx+1; S_Addr+1, T_Addr+1 (5-bit modulo-32 wrap, e.g. 5'h1F->5'h00); out_valid<=0; lat_cnt<=0; go to RD.
  - On handshake, last: out_valid<=0, out_last<=0; done<=1 for exactly one cycle; go to IDLE.
- Timing:
  - Minimum per-pair cost is READ_LAT+1 cycles.
  - With READ_LAT=1, ready tied high and start sampled at edge 0: first out_valid after edge 1; beat k (0-based) valid after edge 2k+1; final handshake at edge 2*PAIRS; done high during the following cycle with busy=0.
- abort:
  - Any non-IDLE state goes to IDLE next edge, with out_valid=0, out_last=0 and no done pulse.
  - abort coinciding with a final handshake: abort wins, no done pulse.
  - abort in IDLE is ignored.
- start and abort together in IDLE: start wins.
- Constant outputs (FS, Y_Sel, T_Sel, D_En, HILO_ld) hold their values in every state, including during reset.

Test Plan:
- Load reg i with 32'hA000_0000+i via the datapath write path; pulse start with ready=1 -> 16 beats, beat k = {s_addr=k, s_data=A000_000k, t_addr=16+k, t_data=A000_0010+k}; out_last only on beat 15; done pulse at edge 32.
- Backpressure: ready low for 5 cycles on beat 3 -> out_valid and all out_* held constant, no address advance; beat 4 follows normally after ready rises.
- PAIRS=4, S_BASE=5'h1E, T_BASE=5'h1F -> S addresses 1E,1F,00,01 and T addresses 1F,00,01,02 (wrap); out_last on beat 3.
- READ_LAT=3, ready=1 -> first out_valid 3 edges after start; 4 cycles between beats.
- abort during beat 7 RD, then start again -> no done pulse; new dump restarts at S=0/T=16; reset asserted mid-OUT -> out_valid=0, busy=0 next cycle.
- Throughout every scenario -> D_En=0, HILO_ld=0, FS=00, Y_Sel=010, T_Sel=0 every cycle (assertion).

Source files
------------

// File: rtl/regfile_dump_ctrl_if.sv
// rtl/regfile_dump_ctrl_if.sv - pair stream from the register-file dump engine to a trace consumer
//
// Signals:
//   out_valid   master->slave  captured S/T pair available
//   out_ready   slave->master  consumer accepts the pair
//   out_s_addr  master->slave  S address of the pair
//   out_s_data  master->slave  S data (ALU pass-through)
//   out_t_addr  master->slave  T address of the pair
//   out_t_data  master->slave  T data
//   out_last    master->slave  final pair of the dump
interface regfile_dump_ctrl_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_s_addr;
    logic [31:0] out_s_data;
    logic [4:0]  out_t_addr;
    logic [31:0] out_t_data;
    logic        out_last;

    modport master (
        output out_valid, out_s_addr, out_s_data, out_t_addr, out_t_data, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_s_addr, out_s_data, out_t_addr, out_t_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - register-file read-out engine streaming S/T pairs to a trace consumer
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, abort        begin a dump (IDLE only) / cancel a dump in progress
//   ALU_OUT, D_OUT      datapath S data (ALU in pass-S) and T-port read data
//   S_Addr, T_Addr      read addresses driven into the datapath
//   FS, Y_Sel, T_Sel,
//   D_En, HILO_ld       constant datapath controls: pass S, select ALU, no writes
//   busy, done          dump in progress / one-cycle completion pulse
//   dump                pair stream (valid/ready) toward the consumer
module regfile_dump_ctrl #(
    parameter int unsigned PAIRS     = 16,
    parameter logic [4:0]  S_BASE    = 5'h00,
    parameter logic [4:0]  T_BASE    = 5'h10,
    parameter int unsigned READ_LAT  = 1,
    parameter logic [4:0]  FS_PASS_S = 5'h00,
    parameter logic [2:0]  Y_SEL_ALU = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] ALU_OUT,
    input  logic [31:0] D_OUT,
    output logic [4:0]  S_Addr,
    output logic [4:0]  T_Addr,
    output logic [4:0]  FS,
    output logic [2:0]  Y_Sel,
    output logic        T_Sel,
    output logic        D_En,
    output logic        HILO_ld,
    output logic        busy,
    output logic        done,
    regfile_dump_ctrl_if.master dump
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [7:0] LAT_LAST = 8'(READ_LAT - 1);
    localparam logic [5:0] IDX_LAST = 6'(PAIRS - 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  lat_cnt_q, lat_cnt_d;
    logic [4:0]  s_addr_q, s_addr_d;
    logic [4:0]  t_addr_q, t_addr_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        done_q, done_d;
    logic [4:0]  out_s_addr_q, out_s_addr_d;
    logic [4:0]  out_t_addr_q, out_t_addr_d;
    logic [31:0] out_s_data_q, out_s_data_d;
    logic [31:0] out_t_data_q, out_t_data_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        lat_cnt_d    = lat_cnt_q;
        s_addr_d     = s_addr_q;
        t_addr_d     = t_addr_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        out_s_addr_d = out_s_addr_q;
        out_t_addr_d = out_t_addr_q;
        out_s_data_d = out_s_data_q;
        out_t_data_d = out_t_data_q;

        // abort beats everything outside IDLE, including a final handshake,
        // so a cancelled dump never reports done.
        if (state_q != IDLE && abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        s_addr_d  = S_BASE;
                        t_addr_d  = T_BASE;
                        idx_d     = '0;
                        lat_cnt_d = '0;
                        state_d   = RD;
                    end
                end
                RD: begin
                    lat_cnt_d = lat_cnt_q + 8'd1;
                    if (lat_cnt_q == LAT_LAST) begin
                        out_s_data_d = ALU_OUT;
                        out_t_data_d = D_OUT;
                        out_s_addr_d = s_addr_q;
                        out_t_addr_d = t_addr_q;
                        out_valid_d  = 1'b1;
                        out_last_d   = (idx_q == IDX_LAST);
                        state_d      = OUT;
                    end
                end
                OUT: begin
                    if (out_valid_q && dump.out_ready) begin
                        out_valid_d = 1'b0;
                        if (out_last_q) begin
                            out_last_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            idx_d     = idx_q + 6'd1;
                            // 5-bit addresses wrap naturally past 5'h1F
                            s_addr_d  = s_addr_q + 5'd1;
                            t_addr_d  = t_addr_q + 5'd1;
                            lat_cnt_d = '0;
                            state_d   = RD;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            lat_cnt_q    <= '0;
            s_addr_q     <= S_BASE;
            t_addr_q     <= T_BASE;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            out_s_addr_q <= '0;
            out_t_addr_q <= '0;
            out_s_data_q <= '0;
            out_t_data_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lat_cnt_q    <= lat_cnt_d;
            s_addr_q     <= s_addr_d;
            t_addr_q     <= t_addr_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            out_s_addr_q <= out_s_addr_d;
            out_t_addr_q <= out_t_addr_d;
            out_s_data_q <= out_s_data_d;
            out_t_data_q <= out_t_data_d;
        end
    end

    assign S_Addr  = s_addr_q;
    assign T_Addr  = t_addr_q;
    assign FS      = FS_PASS_S;
    assign Y_Sel   = Y_SEL_ALU;
    assign T_Sel   = 1'b0;
    assign D_En    = 1'b0;
    assign HILO_ld = 1'b0;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    assign dump.out_valid  = out_valid_q;
    assign dump.out_last   = out_last_q;
    assign dump.out_s_addr = out_s_addr_q;
    assign dump.out_t_addr = out_t_addr_q;
    assign dump.out_s_data = out_s_data_q;
    assign dump.out_t_data = out_t_data_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - directed self-checking bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start   [3];
    logic        abort   [3];
    logic [31:0] alu     [3];
    logic [31:0] dout    [3];
    logic [4:0]  s_addr  [3];
    logic [4:0]  t_addr  [3];
    logic [4:0]  fs      [3];
    logic [2:0]  ysel    [3];
    logic        tsel    [3];
    logic        den     [3];
    logic        hilo    [3];
    logic        busy    [3];
    logic        done    [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_dump_ctrl_if if0 ();
    regfile_dump_ctrl_if if1 ();
    regfile_dump_ctrl_if if2 ();

    // register file model: reg i holds 32'hA000_0000 + i
    for (genvar g = 0; g < 3; g++) begin : g_rf
        assign alu[g]  = 32'hA000_0000 + {27'd0, s_addr[g]};
        assign dout[g] = 32'hA000_0000 + {27'd0, t_addr[g]};
    end

    regfile_dump_ctrl u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .ALU_OUT(alu[0]), .D_OUT(dout[0]), .S_Addr(s_addr[0]), .T_Addr(t_addr[0]),
        .FS(fs[0]), .Y_Sel(ysel[0]), .T_Sel(tsel[0]), .D_En(den[0]), .HILO_ld(hilo[0]),
        .busy(busy[0]), .done(done[0]), .dump(if0.master)
    );

    regfile_dump_ctrl #(.PAIRS(4), .S_BASE(5'h1E), .T_BASE(5'h1F)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .ALU_OUT(alu[1]), .D_OUT(dout[1]), .S_Addr(s_addr[1]), .T_Addr(t_addr[1]),
        .FS(fs[1]), .Y_Sel(ysel[1]), .T_Sel(tsel[1]), .D_En(den[1]), .HILO_ld(hilo[1]),
        .busy(busy[1]), .done(done[1]), .dump(if1.master)
    );

    regfile_dump_ctrl #(.PAIRS(2), .READ_LAT(3)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]),
        .ALU_OUT(alu[2]), .D_OUT(dout[2]), .S_Addr(s_addr[2]), .T_Addr(t_addr[2]),
        .FS(fs[2]), .Y_Sel(ysel[2]), .T_Sel(tsel[2]), .D_En(den[2]), .HILO_ld(hilo[2]),
        .busy(busy[2]), .done(done[2]), .dump(if2.master)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // constant datapath controls, every cycle, every instance
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            check("const_ctrl", {53'd0, fs[i], ysel[i], tsel[i], den[i], hilo[i]},
                  {53'd0, 5'h00, 3'b010, 3'b000});
    end

    logic [4:0] exp_s [4];
    logic [4:0] exp_t [4];
    int         k;
    bit         seen;

    initial begin
        exp_s[0] = 5'h1E; exp_s[1] = 5'h1F; exp_s[2] = 5'h00; exp_s[3] = 5'h01;
        exp_t[0] = 5'h1F; exp_t[1] = 5'h00; exp_t[2] = 5'h01; exp_t[3] = 5'h02;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
        end
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", if0.out_valid, 0);
        check("rst_last", if0.out_last, 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_s_addr", s_addr[0], 5'h00);
        check("rst_t_addr", t_addr[0], 5'h10);
        check("rst_out_sdata", if0.out_s_data, 0);
        check("rst_out_taddr", if0.out_t_addr, 0);
        check("rst_s_addr1", s_addr[1], 5'h1E);
        reset = 1'b0;
        tick();

        // full dump, ready held high
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("a_busy", busy[0], 1);
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e % 2 == 1) begin
                k = (e - 1) / 2;
                check("a_valid", if0.out_valid, 1);
                check("a_s_addr", if0.out_s_addr, k);
                check("a_s_data", if0.out_s_data, 32'hA000_0000 + k);
                check("a_t_addr", if0.out_t_addr, 16 + k);
                check("a_t_data", if0.out_t_data, 32'hA000_0010 + k);
                check("a_last", if0.out_last, (k == 15));
                check("a_done_early", done[0], 0);
            end else begin
                check("a_valid_gap", if0.out_valid, 0);
            end
        end
        check("a_done", done[0], 1);
        check("a_busy_end", busy[0], 0);
        tick();
        check("a_done_pulse", done[0], 0);

        // backpressure on beat 3
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (if0.out_valid && if0.out_s_addr == 5'd3) seen = 1;
        end
        check("b_reach_beat3", seen, 1);
        if0.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("b_hold_valid", if0.out_valid, 1);
            check("b_hold_saddr", if0.out_s_addr, 5'd3);
            check("b_hold_sdata", if0.out_s_data, 32'hA000_0003);
            check("b_hold_taddr", if0.out_t_addr, 5'd19);
            check("b_hold_tdata", if0.out_t_data, 32'hA000_0013);
            check("b_hold_last", if0.out_last, 0);
            check("b_hold_Saddr", s_addr[0], 5'd3);
        end
        if0.out_ready = 1'b1;
        tick();
        check("b_hs_valid", if0.out_valid, 0);
        check("b_adv_Saddr", s_addr[0], 5'd4);
        tick();
        check("b_b4_valid", if0.out_valid, 1);
        check("b_b4_saddr", if0.out_s_addr, 5'd4);
        check("b_b4_tdata", if0.out_t_data, 32'hA000_0014);
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (done[0]) seen = 1;
        end
        check("b_done", seen, 1);

        // wrap across 5'h1F with PAIRS=4
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e % 2 == 1) begin
                k = (e - 1) / 2;
                check("w_valid", if1.out_valid, 1);
                check("w_s_addr", if1.out_s_addr, exp_s[k]);
                check("w_t_addr", if1.out_t_addr, exp_t[k]);
                check("w_s_data", if1.out_s_data, 32'hA000_0000 + exp_s[k]);
                check("w_t_data", if1.out_t_data, 32'hA000_0000 + exp_t[k]);
                check("w_last", if1.out_last, (k == 3));
            end
        end
        check("w_done", done[1], 1);
        tick();

        // READ_LAT=3: valid 3 edges after start, 4 cycles per beat
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("l_valid", if2.out_valid, (e == 3 || e == 7));
            if (e == 3) check("l_b0_last", if2.out_last, 0);
            if (e == 7) begin
                check("l_b1_saddr", if2.out_s_addr, 5'd1);
                check("l_b1_tdata", if2.out_t_data, 32'hA000_0011);
                check("l_b1_last", if2.out_last, 1);
            end
        end
        check("l_done", done[2], 1);
        tick();

        // abort during beat 7 read phase
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 1; e <= 14; e++) tick();
        check("x_rd7_Saddr", s_addr[0], 5'd7);
        check("x_rd7_valid", if0.out_valid, 0);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("x_busy", busy[0], 0);
        check("x_valid", if0.out_valid, 0);
        check("x_done", done[0], 0);
        tick();
        check("x_done_late", done[0], 0);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("x_idle_abort", busy[0], 0);

        // start with abort in IDLE: start wins, restarts at S=0/T=16
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("r_busy", busy[0], 1);
        check("r_Saddr", s_addr[0], 5'd0);
        check("r_Taddr", t_addr[0], 5'd16);
        tick();
        check("r_valid", if0.out_valid, 1);
        check("r_saddr", if0.out_s_addr, 5'd0);
        check("r_tdata", if0.out_t_data, 32'hA000_0010);

        // reset mid-OUT overrides the pending handshake
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("z_valid", if0.out_valid, 0);
        check("z_busy", busy[0], 0);
        check("z_done", done[0], 0);
        check("z_Taddr", t_addr[0], 5'd16);

        // abort on the final handshake suppresses done
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        check("f_last", if1.out_last, 1);
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        check("f_done", done[1], 0);
        check("f_busy", busy[1], 0);
        check("f_valid", if1.out_valid, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
